io_uart_mmio: RTL and testbench

//  MMIO slave on the IO address window: consumes the io_mmio request port and returns

---
 rtl/io_uart_mmio_pkg.sv | 35 +++
 rtl/io_uart_mmio_sync_fifo.sv | 59 +++++
 rtl/io_uart_mmio.sv | 187 ++++++++++++++++++
 tb/tb_io_uart_mmio.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/io_uart_mmio_pkg.sv
// Shared register map, bit positions and TX state encoding for the MMIO UART.
// Replaces the former defines.vh offsets with typed package constants.
package io_uart_mmio_pkg;

    localparam int XLEN = 32;

    typedef enum logic [1:0] {
        UART_REG_TXDATA  = 2'd0,
        UART_REG_STATUS  = 2'd1,
        UART_REG_BAUDDIV = 2'd2,
        UART_REG_CTRL    = 2'd3
    } uart_reg_e;

    localparam int STATUS_FULL    = 0;
    localparam int STATUS_EMPTY   = 1;
    localparam int STATUS_BUSY    = 2;
    localparam int STATUS_OVF     = 3;
    localparam int STATUS_CNT_LSB = 8;

    localparam int CTRL_ENABLE = 0;
    localparam int CTRL_IRQ_EN = 1;

    typedef enum logic [1:0] {
        TX_IDLE,
        TX_START,
        TX_DATA,
        TX_STOP
    } tx_state_e;

    // A divider of zero would stall the bit timer, so it behaves as one.
    function automatic logic [15:0] eff_div(input logic [15:0] d);
        return (d == '0) ? 16'd1 : d;
    endfunction

endpackage

// File: rtl/io_uart_mmio_sync_fifo.sv
// Synchronous FIFO with occupancy count; a pop frees a slot for a push in the same cycle.
module io_uart_mmio_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wdata,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign rdata   = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wdata;
        end
    end

    // Pointers are AW bits wide, so they wrap modulo DEPTH on their own.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/io_uart_mmio.sv
// MMIO slave on the IO window: register decode, 1-cycle handshake, TX FIFO and 8N1 transmitter.
module io_uart_mmio
    import io_uart_mmio_pkg::*;
#(
    parameter int FIFO_DEPTH   = 8,
    parameter int BAUD_DIV_RST = 434
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            io_mmio_req,
    input  logic            io_mmio_we,
    input  logic [XLEN-1:0] io_mmio_addr,
    input  logic [XLEN-1:0] io_mmio_wdata,
    output logic [XLEN-1:0] io_mmio_rdata,
    output logic            io_mmio_ready,
    output logic            uart_tx,
    output logic            tx_irq
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    logic            ready_q;
    logic [XLEN-1:0] rdata_q;
    logic [15:0]     baud_div_q;
    logic            ctrl_en;
    logic            ctrl_irq_en;
    logic            ovf_q;

    logic            accept;
    uart_reg_e       reg_sel;
    logic            wr_txdata;
    logic [XLEN-1:0] read_mux;

    logic            fifo_pop;
    logic [7:0]      fifo_rdata;
    logic            fifo_full;
    logic            fifo_empty;
    logic [CW-1:0]   fifo_count;

    tx_state_e       state;
    logic [15:0]     timer;
    logic [15:0]     div_q;
    logic [2:0]      bit_idx;
    logic [7:0]      shift;
    logic            tx_q;

    logic            unused_bits;

    assign unused_bits = ^{io_mmio_addr[XLEN-1:4], io_mmio_addr[1:0], io_mmio_wdata[XLEN-1:16]};

    assign accept    = io_mmio_req && !ready_q;
    assign reg_sel   = uart_reg_e'(io_mmio_addr[3:2]);
    assign wr_txdata = accept && io_mmio_we && (reg_sel == UART_REG_TXDATA);
    assign fifo_pop  = (state == TX_IDLE) && ctrl_en && !fifo_empty;

    io_uart_mmio_sync_fifo #(
        .WIDTH(8),
        .DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (wr_txdata),
        .wdata (io_mmio_wdata[7:0]),
        .pop   (fifo_pop),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    always_comb begin
        read_mux = '0;
        case (reg_sel)
            UART_REG_TXDATA: read_mux = '0;
            UART_REG_STATUS: begin
                read_mux[STATUS_FULL]               = fifo_full;
                read_mux[STATUS_EMPTY]              = fifo_empty;
                read_mux[STATUS_BUSY]               = (state != TX_IDLE);
                read_mux[STATUS_OVF]                = ovf_q;
                read_mux[STATUS_CNT_LSB +: CW]      = fifo_count;
            end
            UART_REG_BAUDDIV: read_mux[15:0] = baud_div_q;
            UART_REG_CTRL: begin
                read_mux[CTRL_ENABLE] = ctrl_en;
                read_mux[CTRL_IRQ_EN] = ctrl_irq_en;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ready_q     <= 1'b0;
            rdata_q     <= '0;
            baud_div_q  <= 16'(BAUD_DIV_RST);
            ctrl_en     <= 1'b1;
            ctrl_irq_en <= 1'b0;
            ovf_q       <= 1'b0;
        end else begin
            ready_q <= accept;
            if (accept) begin
                rdata_q <= io_mmio_we ? '0 : read_mux;
            end
            // A push into a full FIFO only counts as dropped if no pop frees a slot this cycle.
            if (wr_txdata && fifo_full && !fifo_pop) begin
                ovf_q <= 1'b1;
            end
            if (accept && io_mmio_we) begin
                case (reg_sel)
                    UART_REG_STATUS: begin
                        if (io_mmio_wdata[STATUS_OVF]) begin
                            ovf_q <= 1'b0;
                        end
                    end
                    UART_REG_BAUDDIV: baud_div_q <= io_mmio_wdata[15:0];
                    UART_REG_CTRL: begin
                        ctrl_en     <= io_mmio_wdata[CTRL_ENABLE];
                        ctrl_irq_en <= io_mmio_wdata[CTRL_IRQ_EN];
                    end
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= TX_IDLE;
            timer   <= '0;
            div_q   <= 16'd1;
            bit_idx <= '0;
            shift   <= '0;
            tx_q    <= 1'b1;
        end else begin
            case (state)
                TX_IDLE: begin
                    tx_q <= 1'b1;
                    if (fifo_pop) begin
                        shift <= fifo_rdata;
                        div_q <= eff_div(baud_div_q);
                        timer <= eff_div(baud_div_q) - 16'd1;
                        tx_q  <= 1'b0;
                        state <= TX_START;
                    end
                end
                TX_START: begin
                    if (timer == '0) begin
                        timer   <= div_q - 16'd1;
                        bit_idx <= '0;
                        tx_q    <= shift[0];
                        state   <= TX_DATA;
                    end else begin
                        timer <= timer - 16'd1;
                    end
                end
                TX_DATA: begin
                    if (timer == '0) begin
                        timer <= div_q - 16'd1;
                        if (bit_idx == 3'd7) begin
                            tx_q  <= 1'b1;
                            state <= TX_STOP;
                        end else begin
                            bit_idx <= bit_idx + 3'd1;
                            shift   <= shift >> 1;
                            tx_q    <= shift[1];
                        end
                    end else begin
                        timer <= timer - 16'd1;
                    end
                end
                TX_STOP: begin
                    if (timer == '0) begin
                        state <= TX_IDLE;
                    end else begin
                        timer <= timer - 16'd1;
                    end
                end
                default: state <= TX_IDLE;
            endcase
        end
    end

    assign uart_tx       = tx_q;
    assign tx_irq        = fifo_empty && ctrl_irq_en;
    assign io_mmio_ready = ready_q;
    assign io_mmio_rdata = ready_q ? rdata_q : '0;

endmodule

// File: tb/tb_io_uart_mmio.sv
// Self-checking bench for io_uart_mmio: transaction-level model plus directed literal checks.
module tb_io_uart_mmio;

    localparam int DEPTH = 8;
    localparam int BRST  = 434;

    logic        clk;
    logic        rst_n;
    logic        io_mmio_req;
    logic        io_mmio_we;
    logic [31:0] io_mmio_addr;
    logic [31:0] io_mmio_wdata;
    logic [31:0] io_mmio_rdata;
    logic        io_mmio_ready;
    logic        uart_tx;
    logic        tx_irq;

    int compared;
    int mismatched;

    io_uart_mmio #(
        .FIFO_DEPTH(DEPTH),
        .BAUD_DIV_RST(BRST)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .io_mmio_req  (io_mmio_req),
        .io_mmio_we   (io_mmio_we),
        .io_mmio_addr (io_mmio_addr),
        .io_mmio_wdata(io_mmio_wdata),
        .io_mmio_rdata(io_mmio_rdata),
        .io_mmio_ready(io_mmio_ready),
        .uart_tx      (uart_tx),
        .tx_irq       (tx_irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic frame_bit(input logic [7:0] b, input int idx);
        if (idx == 0) return 1'b0;
        if (idx >= 9) return 1'b1;
        return b[idx-1];
    endfunction

    // Model: a byte queue, a frame timer counting elapsed clocks, and the register file.
    logic [7:0]  mq[$];
    logic        m_ready;
    logic [31:0] m_rdata;
    logic [15:0] m_baud;
    logic        m_en;
    logic        m_irq_en;
    logic        m_ovf;
    logic        m_busy;
    logic        m_line;
    logic [7:0]  m_byte;
    int          m_el;
    int          m_div;

    always @(posedge clk or negedge rst_n) begin : model
        logic        acc;
        logic [31:0] rv;
        if (!rst_n) begin
            mq.delete();
            m_ready  = 1'b0;
            m_rdata  = '0;
            m_baud   = 16'(BRST);
            m_en     = 1'b1;
            m_irq_en = 1'b0;
            m_ovf    = 1'b0;
            m_busy   = 1'b0;
            m_line   = 1'b1;
            m_byte   = '0;
            m_el     = 0;
            m_div    = 1;
        end else begin
            acc = io_mmio_req && !m_ready;
            rv  = '0;
            case (io_mmio_addr[3:2])
                2'd1: rv = {16'h0, 8'(mq.size()), 4'h0, m_ovf, m_busy,
                            (mq.size() == 0), (mq.size() == DEPTH)};
                2'd2: rv = {16'h0, m_baud};
                2'd3: rv = {30'h0, m_irq_en, m_en};
                default: rv = '0;
            endcase
            if (m_busy) begin
                m_el++;
                if (m_el == 10 * m_div) begin
                    m_busy = 1'b0;
                    m_line = 1'b1;
                end else begin
                    m_line = frame_bit(m_byte, m_el / m_div);
                end
            end else if (m_en && mq.size() > 0) begin
                m_byte = mq.pop_front();
                m_div  = (m_baud == 0) ? 1 : int'(m_baud);
                m_el   = 0;
                m_busy = 1'b1;
                m_line = 1'b0;
            end
            if (acc && io_mmio_we) begin
                case (io_mmio_addr[3:2])
                    2'd0: if (mq.size() < DEPTH) mq.push_back(io_mmio_wdata[7:0]);
                          else m_ovf = 1'b1;
                    2'd1: if (io_mmio_wdata[3]) m_ovf = 1'b0;
                    2'd2: m_baud = io_mmio_wdata[15:0];
                    default: begin
                        m_en     = io_mmio_wdata[0];
                        m_irq_en = io_mmio_wdata[1];
                    end
                endcase
            end
            if (acc) m_rdata = io_mmio_we ? 32'h0 : rv;
            m_ready = acc;
        end
    end

    always @(negedge clk) begin
        check("ready", {31'h0, io_mmio_ready}, {31'h0, m_ready});
        check("rdata", io_mmio_rdata, m_ready ? m_rdata : 32'h0);
        check("uart_tx", {31'h0, uart_tx}, {31'h0, m_line});
        check("tx_irq", {31'h0, tx_irq}, {31'h0, (mq.size() == 0) && m_irq_en});
    end

    task automatic mmio_write(input logic [31:0] a, input logic [31:0] d);
        io_mmio_req   = 1'b1;
        io_mmio_we    = 1'b1;
        io_mmio_addr  = a;
        io_mmio_wdata = d;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk);
            #1;
            if (io_mmio_ready) break;
        end
        check("wr_ready", {31'h0, io_mmio_ready}, 32'h1);
        io_mmio_req = 1'b0;
        io_mmio_we  = 1'b0;
    endtask

    task automatic mmio_read(input logic [31:0] a, output logic [31:0] d);
        io_mmio_req  = 1'b1;
        io_mmio_we   = 1'b0;
        io_mmio_addr = a;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk);
            #1;
            if (io_mmio_ready) break;
        end
        check("rd_ready", {31'h0, io_mmio_ready}, 32'h1);
        d = io_mmio_rdata;
        io_mmio_req = 1'b0;
    endtask

    task automatic wait_tx_fall(output logic ok);
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(posedge clk);
            #1;
            if (!uart_tx) begin
                ok = 1'b1;
                return;
            end
        end
    endtask

    localparam logic [31:0] A_TX = 32'h0, A_ST = 32'h4, A_BD = 32'h8, A_CT = 32'hC;

    initial begin
        logic [31:0] rd;
        logic        ok;
        logic [9:0]  exp_frame;
        logic        saw_low;
        compared      = 0;
        mismatched    = 0;
        rst_n         = 1'b0;
        io_mmio_req   = 1'b0;
        io_mmio_we    = 1'b0;
        io_mmio_addr  = '0;
        io_mmio_wdata = '0;
        #23 rst_n = 1'b1;
        @(posedge clk); #1;

        // Reset state
        check("rst_tx", {31'h0, uart_tx}, 32'h1);
        mmio_read(A_ST, rd); check("rst_status", rd, 32'h0000_0002);
        mmio_read(A_BD, rd); check("rst_bauddiv", rd, 32'd434);
        mmio_read(A_CT, rd); check("rst_ctrl", rd, 32'h0000_0001);

        // 0x55 at divider 4: start 0, data 1010_1010 LSB first, stop 1
        mmio_write(A_BD, 32'hFFFF_0004);
        mmio_read(A_BD, rd); check("bauddiv_rb", rd, 32'h0000_0004);
        mmio_write(A_TX, 32'h0000_0055);
        wait_tx_fall(ok); check("frame55_start", {31'h0, ok}, 32'h1);
        exp_frame = 10'b10_1010_1010;
        repeat (2) @(posedge clk);
        #1;
        for (int i = 0; i < 10; i++) begin
            check("frame55_bit", {31'h0, uart_tx}, {31'h0, exp_frame[i]});
            if (i < 9) begin
                repeat (4) @(posedge clk);
                #1;
            end
        end
        repeat (4) @(posedge clk);
        #1;
        mmio_read(A_ST, rd); check("post_frame_status", rd, 32'h0000_0002);

        mmio_write(A_CT, 32'h3);
        check("irq_on_empty", {31'h0, tx_irq}, 32'h1);

        // Divider 0 behaves as 1: a 10-clock frame
        mmio_write(A_BD, 32'h0);
        mmio_read(A_BD, rd); check("bauddiv_zero_rb", rd, 32'h0);
        mmio_write(A_TX, 32'h0000_00A3);
        wait_tx_fall(ok); check("div0_start", {31'h0, ok}, 32'h1);
        repeat (15) @(posedge clk);
        #1;
        mmio_read(A_ST, rd); check("div0_done", rd, 32'h0000_0002);

        // Back-to-back requests with enable off
        mmio_write(A_CT, 32'h0);
        @(posedge clk); #1;
        io_mmio_req   = 1'b1;
        io_mmio_we    = 1'b1;
        io_mmio_addr  = A_TX;
        io_mmio_wdata = 32'h0;
        for (int k = 0; k < 4; k++) begin
            @(posedge clk); #1;
            check("b2b_ready", {31'h0, io_mmio_ready}, (k % 2 == 0) ? 32'h1 : 32'h0);
        end
        io_mmio_req = 1'b0;
        io_mmio_we  = 1'b0;
        mmio_read(A_ST, rd); check("b2b_count", rd, 32'h0000_0200);

        // Overflow: 7 more writes into 6 free slots
        for (int k = 0; k < 7; k++) mmio_write(A_TX, 32'h30 + k);
        mmio_read(A_ST, rd); check("ovf_status", rd, 32'h0000_0809);
        mmio_write(A_ST, 32'h8);
        mmio_read(A_ST, rd); check("ovf_clear", rd, 32'h0000_0801);

        // Full FIFO: push landing on the same edge as the FSM pop
        mmio_write(A_BD, 32'h2);
        mmio_write(A_CT, 32'h1);
        wait_tx_fall(ok); check("full_start", {31'h0, ok}, 32'h1);
        mmio_write(A_TX, 32'h0000_0077);
        repeat (19) @(posedge clk);
        #1;
        mmio_write(A_TX, 32'h0000_0088);
        mmio_read(A_ST, rd); check("push_on_pop", rd, 32'h0000_0805);

        // Reset during a data bit of the 0x00 byte
        repeat (3) @(posedge clk);
        #3;
        check("pre_reset_low", {31'h0, uart_tx}, 32'h0);
        rst_n = 1'b0;
        #1;
        check("reset_tx_high", {31'h0, uart_tx}, 32'h1);
        repeat (3) @(posedge clk);
        #3 rst_n = 1'b1;
        @(posedge clk); #1;
        mmio_read(A_ST, rd); check("post_reset_status", rd, 32'h0000_0002);
        mmio_read(A_BD, rd); check("post_reset_bauddiv", rd, 32'd434);
        saw_low = 1'b0;
        for (int k = 0; k < 40; k++) begin
            @(posedge clk); #1;
            if (!uart_tx) saw_low = 1'b1;
        end
        check("no_residual_frame", {31'h0, saw_low}, 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
